// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : data/instruction port arbiter onto one Wishbone master bus.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  input  logic [31:0] i_adr_i,
  output logic [31:0] i_dat_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_D = 2'd1,
    BUS_I = 2'd2
  } state_t;

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
  localparam logic [3:0] c_SEL_ALL = 4'hF;

  state_t      r_state, w_state_nxt;
  logic        r_last_d, w_last_d_nxt;
  logic [7:0]  r_count, w_count_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_adr, w_adr_nxt;
  logic [31:0] r_wdat, w_wdat_nxt;
  logic [3:0]  r_sel, w_sel_nxt;
  logic [31:0] r_d_dat, w_d_dat_nxt;
  logic [31:0] r_i_dat, w_i_dat_nxt;
  logic        r_d_ack, w_d_ack_nxt;
  logic        r_d_err, w_d_err_nxt;
  logic        r_i_ack, w_i_ack_nxt;
  logic        r_i_err, w_i_err_nxt;

  logic        w_d_elig, w_i_elig, w_grant_d, w_grant_i;
  logic [7:0]  w_count_inc;
  logic        w_fail;

  // A port whose completion pulse is showing this cycle must not be regranted.
  assign w_d_elig    = d_req_i && !r_d_ack && !r_d_err;
  assign w_i_elig    = i_req_i && !r_i_ack && !r_i_err;
  assign w_grant_i   = w_i_elig && (!w_d_elig || r_last_d);
  assign w_grant_d   = w_d_elig && !w_grant_i;
  assign w_count_inc = r_count + 8'd1;
  assign w_fail      = wb_err_i || (!wb_ack_i && (w_count_inc == c_TIMEOUT));

  always_comb begin
    w_state_nxt  = r_state;
    w_last_d_nxt = r_last_d;
    w_count_nxt  = r_count;
    w_we_nxt     = r_we;
    w_adr_nxt    = r_adr;
    w_wdat_nxt   = r_wdat;
    w_sel_nxt    = r_sel;
    w_d_dat_nxt  = r_d_dat;
    w_i_dat_nxt  = r_i_dat;
    w_d_ack_nxt  = 1'b0;
    w_d_err_nxt  = 1'b0;
    w_i_ack_nxt  = 1'b0;
    w_i_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt  = BUS_D;
          w_last_d_nxt = 1'b1;
          w_count_nxt  = 8'd0;
          w_we_nxt     = d_we_i;
          w_adr_nxt    = d_adr_i;
          w_wdat_nxt   = d_dat_i;
          w_sel_nxt    = d_sel_i;
        end else if (w_grant_i) begin
          w_state_nxt  = BUS_I;
          w_last_d_nxt = 1'b0;
          w_count_nxt  = 8'd0;
          w_we_nxt     = 1'b0;
          w_adr_nxt    = i_adr_i;
          w_wdat_nxt   = 32'd0;
          w_sel_nxt    = c_SEL_ALL;
        end
      end
      BUS_D, BUS_I: begin
        if (w_fail) begin
          w_state_nxt = IDLE;
          w_d_err_nxt = (r_state == BUS_D);
          w_i_err_nxt = (r_state == BUS_I);
        end else if (wb_ack_i) begin
          w_state_nxt = IDLE;
          w_d_ack_nxt = (r_state == BUS_D);
          w_i_ack_nxt = (r_state == BUS_I);
          if (r_state == BUS_I) w_i_dat_nxt = wb_dat_i;
          else if (!r_we)       w_d_dat_nxt = wb_dat_i;
        end else begin
          w_count_nxt = w_count_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_count  <= 8'd0;
      r_we     <= 1'b0;
      r_adr    <= 32'd0;
      r_wdat   <= 32'd0;
      r_sel    <= 4'd0;
      r_d_dat  <= 32'd0;
      r_i_dat  <= 32'd0;
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      r_i_ack  <= 1'b0;
      r_i_err  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last_d <= w_last_d_nxt;
      r_count  <= w_count_nxt;
      r_we     <= w_we_nxt;
      r_adr    <= w_adr_nxt;
      r_wdat   <= w_wdat_nxt;
      r_sel    <= w_sel_nxt;
      r_d_dat  <= w_d_dat_nxt;
      r_i_dat  <= w_i_dat_nxt;
      r_d_ack  <= w_d_ack_nxt;
      r_d_err  <= w_d_err_nxt;
      r_i_ack  <= w_i_ack_nxt;
      r_i_err  <= w_i_err_nxt;
    end
  end

  assign wb_cyc_o = (r_state != IDLE);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = r_we;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_wdat;
  assign wb_sel_o = r_sel;
  assign d_dat_o  = r_d_dat;
  assign d_ack_o  = r_d_ack;
  assign d_err_o  = r_d_err;
  assign i_dat_o  = r_i_dat;
  assign i_ack_o  = r_i_ack;
  assign i_err_o  = r_i_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed checks of mem_arbiter with TIMEOUT = 4.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_adr_i = '0, d_dat_i = '0;
  logic [3:0]  d_sel_i = '0;
  logic [31:0] d_dat_o;
  logic        d_ack_o, d_err_o;
  logic        i_req_i = 1'b0;
  logic [31:0] i_adr_i = '0;
  logic [31:0] i_dat_o;
  logic        i_ack_o, i_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
    .d_sel_i(d_sel_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .i_req_i(i_req_i), .i_adr_i(i_adr_i), .i_dat_o(i_dat_o),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    step(); step();
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_wdat", wb_dat_o, 32'd0);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_pulses", {28'd0, d_ack_o, d_err_o, i_ack_o, i_err_o}, 32'd0);
    check("rst_ddat", d_dat_o, 32'd0);
    check("rst_idat", i_dat_o, 32'd0);
    rst_i = 1'b1;

    // contention from reset: data, instruction, then data again
    d_req_i = 1; d_we_i = 0; d_adr_i = 32'h200; d_sel_i = 4'h3;
    i_req_i = 1; i_adr_i = 32'h300;
    step();
    check("c1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("c1_adr", wb_adr_o, 32'h200);
    check("c1_sel", {28'd0, wb_sel_o}, 32'h3);
    check("c1_we", {31'd0, wb_we_o}, 32'd0);
    wb_ack_i = 1; wb_dat_i = 32'hAAAA5555;
    step();
    check("c1_dack", {31'd0, d_ack_o}, 32'd1);
    check("c1_ddat", d_dat_o, 32'hAAAA5555);
    check("c1_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    wb_ack_i = 0;
    step();
    check("c2_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("c2_adr", wb_adr_o, 32'h300);
    check("c2_sel", {28'd0, wb_sel_o}, 32'hF);
    check("c2_wdat", wb_dat_o, 32'd0);
    check("c2_dack_gone", {31'd0, d_ack_o}, 32'd0);
    wb_ack_i = 1; wb_dat_i = 32'h12345678;
    step();
    check("c2_iack", {31'd0, i_ack_o}, 32'd1);
    check("c2_idat", i_dat_o, 32'h12345678);
    check("c2_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    wb_ack_i = 0; i_req_i = 0;
    step();
    check("c3_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("c3_adr", wb_adr_o, 32'h200);
    wb_ack_i = 1; wb_dat_i = 32'h0BADF00D; d_req_i = 0;
    step();
    check("c3_dack", {31'd0, d_ack_o}, 32'd1);
    check("c3_ddat", d_dat_o, 32'h0BADF00D);
    wb_ack_i = 0;
    step();
    check("c3_idle", {31'd0, wb_cyc_o}, 32'd0);

    // single write, request held through the ack cycle
    d_req_i = 1; d_we_i = 1; d_adr_i = 32'h100; d_dat_i = 32'hDEADBEEF; d_sel_i = 4'hF;
    step();
    check("w_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("w_we", {31'd0, wb_we_o}, 32'd1);
    check("w_adr", wb_adr_o, 32'h100);
    check("w_wdat", wb_dat_o, 32'hDEADBEEF);
    wb_ack_i = 1;
    step();
    check("w_dack", {31'd0, d_ack_o}, 32'd1);
    check("w_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    check("w_ddat_kept", d_dat_o, 32'h0BADF00D);
    wb_ack_i = 0;
    step();
    check("w_no_regrant", {31'd0, wb_cyc_o}, 32'd0);
    check("w_dack_once", {31'd0, d_ack_o}, 32'd0);
    step();
    check("w_regrant", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1; d_req_i = 0;
    step();
    check("w2_dack", {31'd0, d_ack_o}, 32'd1);
    wb_ack_i = 0;
    step();

    // bus error with simultaneous ack on a fetch
    i_req_i = 1; i_adr_i = 32'h400;
    step();
    check("e_adr", wb_adr_o, 32'h400);
    wb_err_i = 1; wb_ack_i = 1; wb_dat_i = 32'hFFFFFFFF;
    step();
    check("e_ierr", {31'd0, i_err_o}, 32'd1);
    check("e_iack", {31'd0, i_ack_o}, 32'd0);
    check("e_idat", i_dat_o, 32'h12345678);
    check("e_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    wb_err_i = 0; wb_ack_i = 0; i_req_i = 0;
    step();
    check("e_ierr_once", {31'd0, i_err_o}, 32'd0);

    // timeout: silent slave, requester inputs wiggle mid-transfer
    d_req_i = 1; d_we_i = 0; d_adr_i = 32'h500; d_sel_i = 4'h1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t_cyc_high", {31'd0, wb_cyc_o}, 32'd1);
      check("t_adr_held", wb_adr_o, 32'h500);
      d_adr_i = 32'h600;
    end
    step();
    check("t_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    check("t_derr", {31'd0, d_err_o}, 32'd1);
    check("t_dack", {31'd0, d_ack_o}, 32'd0);
    check("t_ddat", d_dat_o, 32'h0BADF00D);
    d_req_i = 0;
    step();
    check("t_derr_once", {31'd0, d_err_o}, 32'd0);

    // reset during a transfer with wait states, then a late ack
    d_req_i = 1; d_we_i = 1; d_adr_i = 32'h700; d_dat_i = 32'h1; d_sel_i = 4'hF;
    step();
    check("r_cyc", {31'd0, wb_cyc_o}, 32'd1);
    step();
    rst_i = 0;
    step();
    check("r_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    check("r_we", {31'd0, wb_we_o}, 32'd0);
    check("r_adr", wb_adr_o, 32'd0);
    check("r_wdat", wb_dat_o, 32'd0);
    check("r_sel", {28'd0, wb_sel_o}, 32'd0);
    check("r_pulses", {28'd0, d_ack_o, d_err_o, i_ack_o, i_err_o}, 32'd0);
    check("r_ddat", d_dat_o, 32'd0);
    check("r_idat", i_dat_o, 32'd0);
    rst_i = 1; d_req_i = 0; wb_ack_i = 1;
    step();
    check("r_late_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("r_late_dack", {31'd0, d_ack_o}, 32'd0);
    wb_ack_i = 0;
    step();
    check("r_late_dack2", {31'd0, d_ack_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, bus cycles allowed for wb_ack_i/wb_err_i before the arbiter aborts the transfer (range 1..255).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 d_req_i  input  1  data-port request (writeback stage), level, held until d_ack_o or d_err_o.
REQ-005 d_we_i  input  1  data-port write enable.
REQ-006 d_adr_i  input  32  data-port byte address.
REQ-007 d_dat_i  input  32  data-port write data.
REQ-008 d_sel_i  input  4  data-port byte lane selects.
REQ-009 d_dat_o  output  32  data-port read data, valid with d_ack_o.
REQ-010 d_ack_o  output  1  data-port completion, one-cycle pulse.
REQ-011 d_err_o  output  1  data-port bus error/timeout, one-cycle pulse.
REQ-012 i_req_i  input  1  instruction-port read request, level, held until i_ack_o or i_err_o.
REQ-013 i_adr_i  input  32  instruction-port byte address.
REQ-014 i_dat_o  output  32  instruction read data, valid with i_ack_o.
REQ-015 i_ack_o  output  1  instruction-port completion, one-cycle pulse.
REQ-016 i_err_o  output  1  instruction-port bus error/timeout, one-cycle pulse.
REQ-017 wb_cyc_o, wb_stb_o  output  1 each  Wishbone cycle/strobe, always equal.
REQ-018 wb_we_o  output  1  Wishbone write enable.
REQ-019 wb_adr_o  output  32  Wishbone address.
REQ-020 wb_dat_o  output  32  Wishbone write data.
REQ-021 wb_sel_o  output  4  Wishbone byte selects.
REQ-022 wb_dat_i  input  32  Wishbone read data.
REQ-023 wb_ack_i, wb_err_i  input  1 each  Wishbone acknowledge / error.

Function
REQ-024 FSM states SHALL be IDLE, BUS_D, BUS_I; one transfer outstanding at most.
REQ-025 IDLE: eligible request sampled at edge N -> wb_cyc_o/wb_stb_o high from cycle N+1 with all wb_* address/data/sel/we registered from the granted port.
REQ-026 A port is eligible only if its req is high and its ack_o/err_o is not high in that same cycle (prevents regrant of a completed request).
REQ-027 Priority: data port wins when both eligible, except when the previous grant was data and i_req_i is eligible, then instruction wins (no two consecutive data grants while instruction waits).
REQ-028 Instruction grant: wb_we_o=0, wb_sel_o=4'hF, wb_dat_o=0.
REQ-029 wb_* outputs SHALL stay constant throughout BUS_D/BUS_I; requester input changes mid-transfer are ignored.
REQ-030 wb_ack_i at edge M (wb_err_i low): FSM -> IDLE, wb_cyc_o low in M+1, port ack_o high for cycle M+1 only, dat_o = wb_dat_i captured at M (reads; writes leave dat_o unchanged).
REQ-031 wb_err_i at edge M: as REQ-030 but err_o pulses instead of ack_o, dat_o unchanged; wb_err_i takes precedence over simultaneous wb_ack_i.
REQ-032 Timeout counter (8 bits) cleared on grant, incremented each BUS cycle; reaching TIMEOUT with no ack/err -> abort as REQ-031 (err_o pulse, cyc dropped).
REQ-033 wb_ack_i/wb_err_i while IDLE SHALL be ignored.
REQ-034 Minimum per-transfer latency: request edge N, zero-wait ack at N+1, ack_o at N+2; back-to-back grant from IDLE possible at N+2 for the other port.

Reset
REQ-035 rst_i low at an edge: FSM -> IDLE, wb_cyc_o/wb_stb_o/wb_we_o=0, wb_adr_o/wb_dat_o=0, wb_sel_o=0, all ack/err outputs 0, d_dat_o/i_dat_o=0, timeout counter 0, last-grant = instruction.
REQ-036 Reset mid-transfer SHALL drop wb_cyc_o next cycle and deliver no ack/err to the interrupted port.

Verification
REQ-037 Single data write: d_req_i=1, d_we_i=1, d_adr_i=32'h100, d_dat_i=32'hDEADBEEF, d_sel_i=4'hF, slave acks 1st cycle -> wb_we_o=1, wb_adr_o=32'h100 one cycle after request; d_ack_o one cycle, wb_cyc_o low then.
REQ-038 Contention: d_req_i and i_req_i rise same cycle, both held -> data granted first, instruction second, data third only after instruction ack; i_dat_o = slave data 32'h12345678.
REQ-039 Bus error: slave asserts wb_err_i and wb_ack_i together on instruction fetch -> i_err_o pulse, i_ack_o stays 0, i_dat_o unchanged.
REQ-040 Timeout: TIMEOUT=4, slave never responds -> wb_cyc_o high exactly 4 cycles, then d_err_o single pulse, FSM IDLE.
REQ-041 Reset mid-transfer: rst_i low during BUS_D with 3 wait states -> all outputs zero next cycle, no d_ack_o/d_err_o, late wb_ack_i ignored.
REQ-042 Held request after ack: d_req_i kept high during d_ack_o cycle -> no regrant in that cycle; new transfer starts only on the cycle after.
